// File: rtl/histogram_scanner.sv
// histogram_scanner: two-pass statistics sweep over a histogram accumulator.
// Pass 1 sums all bins and finds the mode; pass 2 runs a cumulative sum to
// locate the median bin. Results are published together on a one-cycle done.
module histogram_scanner #(
  parameter  int MAX_NUMBER = 127,
  parameter  int SIZE       = 7,
  parameter  int RD_LAT     = 2,
  localparam int ADDR_W     = $clog2(MAX_NUMBER),
  localparam int TW         = ADDR_W + SIZE
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic [ADDR_W-1:0] rd_adr,
  input  logic [SIZE-1:0]   rd_data,
  output logic              hold,
  output logic              busy,
  output logic              done,
  output logic [TW-1:0]     total,
  output logic [ADDR_W-1:0] mode_bin,
  output logic [SIZE-1:0]   mode_count,
  output logic [ADDR_W-1:0] median_bin,
  output logic              empty
);

  localparam int N = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, FINISH} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;         // issue counter; MSB set = pass fully issued
  logic [TW-1:0]       sum_q, sum_d;
  logic [TW-1:0]       cum_q, cum_d;
  logic [SIZE-1:0]     max_cnt_q, max_cnt_d;
  logic [ADDR_W-1:0]   max_bin_q, max_bin_d;
  logic [ADDR_W-1:0]   med_q, med_d;
  logic                found_q, found_d;

  logic [RD_LAT-1:0]   tag_vld_q;
  logic [ADDR_W-1:0]   tag_adr_q [RD_LAT];

  logic [TW-1:0]       total_q;
  logic [ADDR_W-1:0]   mode_bin_q, median_bin_q;
  logic [SIZE-1:0]     mode_count_q;
  logic                empty_q, done_q;

  logic                issue, take, last, load;
  logic [ADDR_W-1:0]   take_adr;
  logic [TW:0]         target;

  assign issue    = ((state_q == PASS1) || (state_q == PASS2)) && !cnt_q[ADDR_W];
  assign take     = tag_vld_q[RD_LAT-1];
  assign take_adr = tag_adr_q[RD_LAT-1];
  assign last     = take && (take_adr == ADDR_W'(N - 1));
  assign target   = ({1'b0, sum_q} + (TW + 1)'(1)) >> 1;

  // Next-state logic for the FSM and the working datapath.
  // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cum_d     = cum_q;
    max_cnt_d = max_cnt_q;
    max_bin_d = max_bin_q;
    med_d     = med_q;
    found_d   = found_q;

    if (issue) cnt_d = cnt_q + (ADDR_W + 1)'(1);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (START) begin
          state_d   = PASS1;
          sum_d     = '0;
          cum_d     = '0;
          max_cnt_d = '0;
          max_bin_d = '0;
          med_d     = '0;
          found_d   = 1'b0;
        end
      end
      PASS1: begin
        if (take) begin
          sum_d = sum_q + TW'(rd_data);
          // Strictly greater keeps the lowest bin on ties.
          if (rd_data > max_cnt_q) begin
            max_cnt_d = rd_data;
            max_bin_d = take_adr;
          end
        end
        if (last) begin
          cnt_d   = '0;
          state_d = (sum_d == '0) ? FINISH : PASS2;
        end
      end
      PASS2: begin
        if (take) begin
          cum_d = cum_q + TW'(rd_data);
          if (!found_q && ({1'b0, cum_d} >= target)) begin
            med_d   = take_adr;
            found_d = 1'b1;
          end
        end
        if (last) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results are published on the edge that enters FINISH.
  assign load = (state_d == FINISH) && (state_q != FINISH);

  // State, working and result registers with synchronous reset.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sum_q        <= '0;
      cum_q        <= '0;
      max_cnt_q    <= '0;
      max_bin_q    <= '0;
      med_q        <= '0;
      found_q      <= 1'b0;
      tag_vld_q    <= '0;
      total_q      <= '0;
      mode_bin_q   <= '0;
      mode_count_q <= '0;
      median_bin_q <= '0;
      empty_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      cum_q        <= cum_d;
      max_cnt_q    <= max_cnt_d;
      max_bin_q    <= max_bin_d;
      med_q        <= med_d;
      found_q      <= found_d;
      tag_vld_q[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) tag_vld_q[i] <= tag_vld_q[i-1];
      done_q       <= load;
      if (load) begin
        total_q      <= sum_d;
        mode_bin_q   <= max_bin_d;
        mode_count_q <= max_cnt_d;
        median_bin_q <= med_d;
        empty_q      <= (sum_d == '0);
      end
    end
  end

  // Read-address tag pipeline, paired with the valid bits above.
  // NOTE: no reset here; the addresses are only looked at when their valid bit (which is reset) is set.
  always_ff @(posedge CLK) begin
    tag_adr_q[0] <= cnt_q[ADDR_W-1:0];
    for (int i = 1; i < RD_LAT; i++) tag_adr_q[i] <= tag_adr_q[i-1];
  end

  assign busy       = (state_q != IDLE);
  assign hold       = busy;
  assign rd_adr     = issue ? cnt_q[ADDR_W-1:0] : '0;
  assign done       = done_q;
  assign total      = total_q;
  assign mode_bin   = mode_bin_q;
  assign mode_count = mode_count_q;
  assign median_bin = median_bin_q;
  assign empty      = empty_q;

endmodule

// File: doc/histogram_scanner.md
# histogram_scanner

Post-accumulation statistics stage placed directly downstream of the histogram accumulator. On a start pulse it sweeps every bin address through the accumulator's read port and collects per-bin counts. It reports the total sample count, the mode bin and its count, and the median bin. The `hold` output keeps the accumulator's increment enable gated off while a scan runs.

## Interface

Parameters:
- `MAX_NUMBER`, default 127: largest sample value. `ADDR_W = $clog2(MAX_NUMBER)` and `N = 2**ADDR_W` bins, i.e. addresses 0..N-1.
- `SIZE`, default 7: width of one bin count.
- `RD_LAT`, default 2: cycles from `rd_adr` presented to matching `rd_data` valid.

Ports:
- `CLK`, input, 1: single clock; all logic on its rising edge.
- `RST`, input, 1: reset, synchronous, active-high. Clears the FSM and all outputs.
- `START`, input, 1: scan request, sampled only in IDLE.
- `rd_adr`, output, ADDR_W: bin address driven to the accumulator's address/`d_in`.
- `rd_data`, input, SIZE: bin count returned by the accumulator.
- `hold`, output, 1: high while busy. Upstream must force accumulator enable low while it is high.
- `busy`, output, 1: scan in progress.
- `done`, output, 1: one-cycle pulse when results update.
- `total`, output, ADDR_W+SIZE: sum of all bins.
- `mode_bin`, output, ADDR_W: bin with the largest count.
- `mode_count`, output, SIZE: count of `mode_bin`.
- `median_bin`, output, ADDR_W: lowest bin whose cumulative count is at least `ceil(total/2)`.
- `empty`, output, 1: `total == 0`.

## Operation

- FSM states: IDLE, PASS1, PASS2, FINISH.
  - IDLE -> PASS1 on `START`.
  - PASS1 -> PASS2 after the last PASS1 datum, when total != 0.
  - PASS1 -> FINISH when total == 0.
  - PASS2 -> FINISH after the last PASS2 datum.
  - FINISH -> IDLE unconditionally.
- Address issue: in each pass, `rd_adr` steps 0, 1, ..., N-1, one address per cycle.
- Read tagging: a RD_LAT-deep shift register carries a valid bit and the address of each read, so each `rd_data` is paired with its bin.
- PASS1:
  - Accumulate `total` and track the maximum count.
  - Replace the current maximum only on strictly greater. Ties therefore resolve to the lowest bin index.
  - Initial maximum is bin 0 with count 0.
- PASS2:
  - `target = (total + 1) >> 1`.
  - Run a cumulative sum of width ADDR_W+SIZE. Latch `median_bin` at the first bin where the cumulative sum is at least `target`. Later bins never overwrite it.
  - The pass always runs its full length, so timing is deterministic.
- Arithmetic is unsigned. ADDR_W+SIZE bits hold `N*(2**SIZE-1)` without overflow; no saturation logic.
- Empty histogram: PASS2 is skipped; `empty=1` and `mode_bin`, `mode_count`, `median_bin` are all 0.
- Outputs:
  - Registered.
  - Updated together in FINISH, with `done=1` for that cycle.
  - Held stable until the next FINISH or `RST`.
  - Working registers are internal; outputs never show partial values.
- `START` while busy is ignored, not queued.
- `rd_adr` is 0 whenever not issuing addresses.

## Timing

- Reset: after a cycle with `RST=1`, every output is 0 and the FSM is in IDLE. Reset wins over `START` in the same cycle.
- `RST` mid-scan aborts: next cycle `busy=hold=0`, all outputs 0, no `done` pulse.
- Cycle counting: call the cycle in which `START` is sampled in IDLE cycle 0.
  - `busy`/`hold` are high from cycle 1 through the FINISH cycle inclusive.
  - PASS1 addresses appear on cycles 1..N. Data is consumed on cycles 1+RD_LAT..N+RD_LAT.
  - PASS2 addresses appear on cycles N+RD_LAT+1..2N+RD_LAT. Data is consumed through 2N+2RD_LAT.
  - Non-empty scan: FINISH/`done` at cycle 2N+2RD_LAT+1, which is 261 at defaults.
  - Empty scan: FINISH/`done` at cycle N+RD_LAT+1, which is 131 at defaults.
- `busy` falls the cycle after `done`. A new `START` is accepted in that cycle or later.
- `rd_data` is sampled only in tagged-valid cycles. Values in other cycles have no effect.

## Test plan

Defaults throughout; the bench is a behavioural memory with 2-cycle read latency.
- All bins 0, `START` -> `done` at cycle 131; `total=0`, `empty=1`, `mode_bin=0`, `mode_count=0`, `median_bin=0`.
- Bin 5 = 3, others 0 -> `done` at cycle 261; `total=3`, `mode_bin=5`, `mode_count=3`, `median_bin=5`, `empty=0`.
- Bins 10=2, 20=2, 30=1 -> `total=5`, `mode_bin=10` (tie goes to lowest), `mode_count=2`, target 3, `median_bin=20`.
- All 128 bins = 127 -> `total=16256`, `mode_bin=0`, `mode_count=127`, target 8128, `median_bin=63`. No overflow.
- Reset and `START` handling:
  - `RST` pulsed in the middle of PASS2 -> next cycle `busy=0`, all outputs 0, no `done`.
  - A fresh `START` after that reproduces the earlier expected results.
  - `START` pulses while busy are ignored; exactly one `done` per accepted start.
- `hold`/`rd_adr` checks:
  - `hold` is high from cycle 1 to the FINISH cycle.
  - `rd_adr` is a gap-free 0..127 ramp in each pass.
  - `rd_adr` is 0 in IDLE and FINISH.
